// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding and sizing for the UART transmit arbiter
package uart_arb_pkg;

  // Largest requester count the arbiter is built for.
  localparam int NREQ_MAX = 4;

  // Width of the round-robin pointer, sized for the largest configuration.
  localparam int PTR_W = $clog2(NREQ_MAX);

  // Value tx_byte idles at after reset (UART line-idle pattern).
  localparam logic [7:0] TX_BYTE_RST = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_ACK  = 3'd4,
    ST_HOLD = 3'd5
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin search, first request at or above ptr wins
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Walk upward from ptr with wrap-around; the first asserted request is granted.
  always_comb begin
    int          sum;
    logic [IW-1:0] idx;
    logic        found;
    gnt   = '0;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr) + k;
      if (sum >= N) begin
        sum = sum - N;
      end
      idx = IW'(sum);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - packet-granular arbiter sharing one UART transmitter; UART_TX_ARB_TIMEOUT_EN adds a WAIT/HOLD abort timer
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int          NREQ        = 2,
  parameter logic [31:0] TIMEOUT_CYC = 32'd8000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_byte,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_done,
  output logic              busy,
  output logic              timeout_err
);

  // Reject configurations the pointer and state widths cannot represent.
  if (NREQ < 2 || NREQ > NREQ_MAX || TIMEOUT_CYC == 32'd0) begin : g_bad_cfg
    $error("uart_tx_arb: NREQ must be 2..NREQ_MAX and TIMEOUT_CYC nonzero");
  end

  arb_state_e        state_q;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   req_ready_q;
  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  rr_ptr_d;
  logic [7:0]        tx_byte_q;
  logic              tx_valid_q;
  logic              last_q;
  logic [NREQ-1:0]   arb_gnt;
  logic [7:0]        sel_byte;
  logic              sel_last;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PTR_W)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  // Route the owner's byte/last flag and compute the pointer slot just past the owner.
  always_comb begin
    sel_byte = 8'h00;
    sel_last = 1'b0;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        sel_byte = req_byte[8*i +: 8];
        sel_last = req_last[i];
        rr_ptr_d = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        timeout_q;
  logic        to_hit;

  // The abort fires on the cycle the count has spanned TIMEOUT_CYC edges since WAIT/HOLD entry.
  assign to_hit = (to_cnt_q == TIMEOUT_CYC - 32'd1);
`endif

  // Arbitration FSM: grant, one-byte handshake with the UART, hold ownership to end of packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      req_ready_q <= '0;
      rr_ptr_q    <= '0;
      tx_byte_q   <= TX_BYTE_RST;
      tx_valid_q  <= 1'b0;
      last_q      <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      tx_valid_q  <= 1'b0;
      req_ready_q <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            grant_q <= arb_gnt;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          tx_byte_q  <= sel_byte;
          last_q     <= sel_last;
          tx_valid_q <= 1'b1;
          state_q    <= ST_WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
          to_cnt_q   <= '0;
`endif
        end
        ST_WAIT: begin
          if (tx_done) begin
            req_ready_q <= grant_q;
            state_q     <= ST_ACK;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (to_hit) begin
            timeout_q <= 1'b1;
            grant_q   <= '0;
            rr_ptr_q  <= rr_ptr_d;
            state_q   <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
`endif
        end
        ST_ACK: begin
          if (last_q) begin
            grant_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ST_IDLE;
          end else begin
            state_q  <= ST_HOLD;
`ifdef UART_TX_ARB_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        ST_HOLD: begin
          if (|(req_valid & grant_q)) begin
            state_q <= ST_SEND;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (to_hit) begin
            timeout_q <= 1'b1;
            grant_q   <= '0;
            rr_ptr_q  <= rr_ptr_d;
            state_q   <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
`endif
        end
        default: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign req_ready = req_ready_q;
  assign tx_byte   = tx_byte_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 2, is the number of byte-stream requesters (legal 2..4).
REQ-002 Parameter TIMEOUT_CYC, default 32'd8000, is the maximum cycles allowed in WAIT or HOLD before abort.
REQ-003 clk  input  1  sole clock, rising edge; clock is clk and reset is rst, and reset is synchronous and active-high.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  NREQ  per-requester byte available; held until the matching req_ready.
REQ-006 req_byte  input  NREQ*8  per-requester byte; slice i = [8i+7:8i].
REQ-007 req_last  input  NREQ  per-requester flag marking the final byte of the packet.
REQ-008 req_ready  output  NREQ  one-cycle pulse; the byte of requester i has been fully transmitted.
REQ-009 grant  output  NREQ  one-hot owner of the UART; all zero when idle.
REQ-010 tx_byte  output  8  byte presented to the UART transmitter.
REQ-011 tx_valid  output  1  one-cycle start pulse to the UART transmitter.
REQ-012 tx_done  input  1  one-cycle byte-complete pulse from the UART transmitter.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 timeout_err  output  1  one-cycle pulse on abort.

Function
REQ-015 The FSM SHALL have states IDLE, SEND, WAIT, ACK and HOLD.
REQ-016 IDLE: when any req_valid is high, the block SHALL register grant to the first valid requester, searching upward from rr_ptr with wrap-around, and go to SEND.
REQ-017 SEND: the block SHALL latch req_byte and req_last of the granted requester, drive tx_byte with that byte, pulse tx_valid for exactly one cycle, and go to WAIT.
REQ-018 tx_byte SHALL hold the latched value until the next SEND.
REQ-019 WAIT: on tx_done the block SHALL pulse req_ready[grant] on the next cycle and go to ACK; tx_done in any other state SHALL be ignored.
REQ-020 ACK (one cycle): if the latched last flag is set, the block SHALL clear grant, set rr_ptr to (granted index + 1) mod NREQ, and go to IDLE; otherwise it SHALL go to HOLD.
REQ-021 HOLD: the block SHALL keep grant and go to SEND when req_valid[grant] is high; other requesters SHALL NOT pre-empt.
REQ-022 Minimum latency from req_valid high in IDLE to tx_valid SHALL be 2 cycles.
REQ-023 Simultaneous requests in IDLE SHALL resolve by round-robin from rr_ptr; an uncontested requester SHALL be granted regardless of rr_ptr.
REQ-024 req_valid changing for a non-granted requester mid-packet SHALL have no effect.
REQ-025 At most one tx_valid SHALL be outstanding; no tx_valid SHALL be issued before the prior tx_done.

Reset
REQ-026 rst SHALL force IDLE and clear grant, req_ready, tx_valid, busy, timeout_err and rr_ptr to 0, and set tx_byte to 8'hFF, on the next edge, including mid-packet.

Configuration
REQ-027 With UART_TX_ARB_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT and HOLD, reload on state entry, and on reaching TIMEOUT_CYC it SHALL pulse timeout_err, clear grant, advance rr_ptr past the owner, and go to IDLE with no req_ready pulse.
REQ-028 Without UART_TX_ARB_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied 0, and WAIT and HOLD SHALL wait indefinitely.

Structure
REQ-029 The state encoding (IDLE=3'd1, SEND=3'd2, WAIT=3'd3, ACK=3'd4, HOLD=3'd5) and the NREQ maximum SHALL live in shared package uart_arb_pkg.
REQ-030 The round-robin priority search SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot gnt), purely combinational; uart_tx_arb SHALL register its result.

Verification
REQ-031 Single requester: req0 sends 8'h55 with last=1 and tx_done arrives 20 cycles after tx_valid -> tx_valid 2 cycles after req_valid, tx_byte=8'h55, req_ready[0] 1 cycle after tx_done, back in IDLE, rr_ptr=1.
REQ-032 Contention: req0 and req1 assert together with rr_ptr=0 -> req0 packet {8'hA1, 8'hA2 last} completes, then req1 8'hB1 is granted without any idle gap beyond IDLE->SEND.
REQ-033 No pre-emption: req1 raises valid while req0 is in HOLD -> grant stays 4'b0001 until req0's last byte is acknowledged.
REQ-034 Timeout (macro defined, TIMEOUT_CYC=100): tx_done is never returned -> timeout_err pulses exactly 100 cycles after WAIT entry, grant=0, and no req_ready.
REQ-035 Reset mid-WAIT: rst is asserted for 1 cycle -> all outputs at reset values next cycle, and a late tx_done is ignored.
REQ-036 Spurious tx_done is injected in IDLE and SEND -> no req_ready and no state change.
